// File: rtl/mont_domain_conv.sv
// mont_domain_conv: streaming normal <-> Montgomery domain converter (R = 2^16) for Kyber coefficients.
// Optional macro CANON_OUT_EN adds a registered stage mapping results from (-Q, Q) into [0, Q).
module mont_domain_conv #(
  parameter int N    = 256,
  parameter int Q    = 3329,
  parameter int QINV = 62209,
  parameter int R2   = 1353
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_coeff,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_coeff,
  output logic        out_last
);

  localparam int                 CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]      CNT_MAX  = CW'(N - 1);
  localparam logic signed [31:0] MUL_TO   = 32'(R2);
  localparam logic signed [31:0] MUL_FROM = 32'sd1;
  localparam logic [15:0]        QINV16   = 16'(QINV);
  localparam logic signed [31:0] Q32      = 32'(Q);

  logic               en;
  logic               accept;
  logic [CW-1:0]      cnt;
  logic signed [31:0] a_ext;
  logic signed [31:0] mul_sel;
  logic signed [31:0] prod;

  logic               s1_valid;
  logic               s1_last;
  logic signed [31:0] s1_p;

  logic [15:0]        u_raw;
  logic signed [31:0] uq;
  logic signed [31:0] diff;

  logic               s2_valid;
  logic               s2_last;
  logic signed [15:0] s2_r;

  // One enable freezes every stage at once, so a stalled output also blocks the input.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  assign a_ext   = 32'(signed'(in_coeff));
  assign mul_sel = in_mode ? MUL_FROM : MUL_TO;
  assign prod    = a_ext * mul_sel;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_last  <= in_valid && (cnt == CNT_MAX);
      s1_p     <= prod;
    end
  end

  // Montgomery reduction: low 16 bits of p - u*Q cancel exactly, so the shift is exact.
  assign u_raw = s1_p[15:0] * QINV16;
  assign uq    = 32'(signed'(u_raw)) * Q32;
  assign diff  = s1_p - uq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_r     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_r     <= 16'(diff >>> 16);
    end
  end

`ifdef CANON_OUT_EN
  localparam logic signed [15:0] Q16 = 16'(Q);

  logic               s3_valid;
  logic               s3_last;
  logic signed [15:0] s3_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_r     <= '0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      s3_r     <= s2_r[15] ? s2_r + Q16 : s2_r;
    end
  end

  assign out_valid = s3_valid;
  assign out_last  = s3_last;
  assign out_coeff = s3_r;
`else
  assign out_valid = s2_valid;
  assign out_last  = s2_last;
  assign out_coeff = s2_r;
`endif

endmodule

// File: tb/tb_mont_domain_conv.sv
// tb_mont_domain_conv: scoreboard bench for mont_domain_conv; directed steps in one initial block.
// Inputs change 1 ns after posedge; outputs are sampled on the negedge.
`timescale 1ns/1ps
module tb_mont_domain_conv;

  localparam int N    = 256;
  localparam int Q    = 3329;
  localparam int QINV = 62209;
  localparam int R2   = 1353;
`ifdef CANON_OUT_EN
  localparam int LAT    = 3;
  localparam int EXP_T1 = 2285;
`else
  localparam int LAT    = 2;
  localparam int EXP_T1 = -1044;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_coeff;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_coeff;
  logic        out_last;

  mont_domain_conv #(.N(N), .Q(Q), .QINV(QINV), .R2(R2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coeff  (in_coeff),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeff (out_coeff),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   coeff;
    logic last;
    logic chk_lat;
    int   acc_cyc;
    logic chk_rt;
    int   rt_a;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   tb_cnt = 0;
  int   a_arr[N];
  int   m_arr[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference fqmul: Montgomery product of a and b with R = 2^16.
  function automatic int fqmul(input int a, input int b);
    longint p;
    longint pr;
    longint u;
    longint t;
    int     r;
    p  = longint'(a) * longint'(b);
    pr = p * longint'(QINV);
    u  = pr & 64'hFFFF;
    if (u >= 32768) u = u - 65536;
    t = p - u * longint'(Q);
    r = int'(t / 65536);
`ifdef CANON_OUT_EN
    if (r < 0) r = r + Q;
`endif
    return r;
  endfunction

  function automatic int model(input int a, input logic mode);
    return fqmul(a, mode ? 1 : R2);
  endfunction

  // Offer one beat; push its expectation on the accepting edge. Returns 1 ns after that edge.
  task automatic send(input int a, input logic mode, input int expv,
                      input logic chk_lat, input logic chk_rt, input int rt_a);
    exp_t e;
    logic accepted;
    int   acc;
    accepted = 1'b0;
    acc      = 0;
    in_valid = 1'b1;
    in_coeff = 16'(a);
    in_mode  = mode;
    for (int w = 0; w < 200 && !accepted; w++) begin
      @(negedge clk);
      accepted = in_ready;
      acc      = cyc;
      @(posedge clk);
      if (accepted) begin
        e.coeff   = expv;
        e.last    = (tb_cnt == N - 1);
        e.chk_lat = chk_lat;
        e.acc_cyc = acc;
        e.chk_rt  = chk_rt;
        e.rt_a    = rt_a;
        sb.push_back(e);
        tb_cnt = (tb_cnt + 1) % N;
      end
      #1;
    end
    check("accept_in_time", accepted, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    check({tag, "_drained"}, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    sb.delete();
    tb_cnt = 0;
    #1;
    check({tag, "_valid_async"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_coeff"}, 32'(signed'(out_coeff)), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_valid_after"}, out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pop on every transfer, plus stall-hold and back-pressure checks.
  logic        stall_prev = 1'b0;
  logic [15:0] held_coeff = '0;
  logic        held_last  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_coeff_held", 32'(signed'(out_coeff)), 32'(signed'(held_coeff)));
        check("stall_last_held", out_last, held_last);
      end
      if (out_valid && !out_ready) check("in_ready_in_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("coeff", 32'(signed'(out_coeff)), mon_e.coeff);
          check("last", out_last, mon_e.last);
          if (mon_e.chk_lat) check("latency", cyc - mon_e.acc_cyc, LAT);
          if (mon_e.chk_rt) check("roundtrip", ((int'(signed'(out_coeff)) % Q) + Q) % Q, mon_e.rt_a);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_coeff = out_coeff;
      held_last  = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_coeff  = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_coeff", 32'(signed'(out_coeff)), 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: to_mont of 1, with latency
    send(1, 1'b0, EXP_T1, 1'b1, 1'b0, 0);
    drain("t1");

    // Test 2: from_mont of 2285, and zero in both modes
    send(2285, 1'b1, 1, 1'b1, 1'b0, 0);
    send(0, 1'b0, 0, 1'b1, 1'b0, 0);
    send(0, 1'b1, 0, 1'b1, 1'b0, 0);
    drain("t2");

    // Test 3: round trip over one aligned polynomial per direction
    pulse_reset("t3_rst");
    for (int i = 0; i < N; i++) a_arr[i] = int'($urandom_range(0, Q - 1));
    a_arr[0] = 0;
    a_arr[1] = Q - 1;
    for (int i = 0; i < N; i++) m_arr[i] = model(a_arr[i], 1'b0);
    for (int i = 0; i < N; i++) send(a_arr[i], 1'b0, m_arr[i], 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) send(m_arr[i], 1'b1, model(m_arr[i], 1'b1), 1'b0, 1'b1, a_arr[i]);
    drain("t3");

    // Test 4: back-pressure, 5 stalled cycles mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a = int'($urandom_range(0, 6000)) - 3000;
          send(a, i[0], model(a, i[0]), 1'b0, 1'b0, 0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("t4");

    // Test 5: modes alternate on consecutive beats
    send(1000, 1'b0, model(1000, 1'b0), 1'b0, 1'b0, 0);
    send(1000, 1'b1, model(1000, 1'b1), 1'b0, 1'b0, 0);
    send(-1234, 1'b0, model(-1234, 1'b0), 1'b0, 1'b0, 0);
    send(-1234, 1'b1, model(-1234, 1'b1), 1'b0, 1'b0, 0);
    send(32767, 1'b0, model(32767, 1'b0), 1'b0, 1'b0, 0);
    send(-32767, 1'b1, model(-32767, 1'b1), 1'b0, 1'b0, 0);
    drain("t5");

    // Test 6: reset with beats in flight, then a fresh polynomial
    pulse_reset("t6_pre");
    for (int i = 0; i < 100; i++) begin
      a = int'($urandom_range(0, 65534)) - 32767;
      send(a, 1'(i % 3 == 0), model(a, 1'(i % 3 == 0)), 1'b0, 1'b0, 0);
    end
    check("t6_inflight", out_valid, 1);
    pulse_reset("t6_rst");
    for (int i = 0; i < N; i++) begin
      a = int'($urandom_range(0, 65534)) - 32767;
      send(a, 1'b0, model(a, 1'b0), 1'b0, 1'b0, 0);
    end
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
